// File: rtl/inst_stream_loader_pkg.sv
// Shared types and widths for the instruction stream loader.
// Load-port widths, sync marker default and FSM states.
package inst_stream_loader_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEN0       = 3'd1,
    LEN1       = 3'd2,
    DATA       = 3'd3,
    WRITE_HOLD = 3'd4,
    CSUM       = 3'd5
  } state_e;

endpackage

// File: rtl/inst_stream_loader_byte_word_pack.sv
// Packs payload bytes LSB-first into 32-bit words.
// Also keeps the running XOR checksum of the payload.
module inst_stream_loader_byte_word_pack
  import inst_stream_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic              lane_last,
  output logic              word_valid,
  output logic [INST_W-1:0] word,
  output logic [7:0]        csum
);

  logic [1:0]        lane;
  logic [INST_W-1:0] buffer;

  assign lane_last  = (lane == 2'd3);
  assign word_valid = shift_en && lane_last;
  assign word       = {byte_in, buffer[INST_W-1:8]};

  // Lane counter, shift buffer and checksum advance per payload byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane   <= '0;
      buffer <= '0;
      csum   <= '0;
    end else if (clr) begin
      lane   <= '0;
      buffer <= '0;
      csum   <= '0;
    end else if (shift_en) begin
      lane   <= lane + 2'd1;
      buffer <= word;
      csum   <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/inst_stream_loader.sv
// Frame loader for the instruction memory load port.
// Holds the core in reset until a frame checksum verifies.
module inst_stream_loader
  import inst_stream_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] Inst_addr_load,
  output logic [INST_W-1:0] Inst_load,
  output logic              load_en,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, idx_q;
  logic              accept, start, cap_lo, cap_hi;
  logic              shift_en, csum_chk;
  logic              lane_last, word_valid;
  logic [INST_W-1:0] word;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] offset;

  assign byte_ready = (state_q != WRITE_HOLD);
  assign accept     = byte_valid && byte_ready;
  assign offset     = {16'h0, idx_q} * ADDR_STEP;

  inst_stream_loader_byte_word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .shift_en   (shift_en),
    .byte_in    (byte_data),
    .lane_last  (lane_last),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-byte control strobes
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    shift_en = 1'b0;
    csum_chk = 1'b0;
    case (state_q)
      IDLE: if (accept && byte_data == SYNC_BYTE) begin
        start   = 1'b1;
        state_d = LEN0;
      end
      LEN0: if (accept) begin
        cap_lo  = 1'b1;
        state_d = LEN1;
      end
      LEN1: if (accept) begin
        cap_hi  = 1'b1;
        state_d = ({byte_data, count_q[7:0]} == '0) ? CSUM : DATA;
      end
      DATA: if (accept) begin
        shift_en = 1'b1;
        if (lane_last && ({1'b0, idx_q} + 17'd1 == {1'b0, count_q}))
          state_d = CSUM;
      end
      CSUM: if (accept) begin
        csum_chk = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count, index, write port and core-reset/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      idx_q          <= '0;
      Inst_addr_load <= '0;
      Inst_load      <= '0;
      load_en        <= 1'b0;
      cpu_rst_n      <= 1'b0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      load_en <= 1'b0;
      if (start) begin
        idx_q     <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        cpu_rst_n <= 1'b0;
      end
      if (cap_lo) count_q[7:0]  <= byte_data;
      if (cap_hi) count_q[15:8] <= byte_data;
      if (word_valid) begin
        load_en        <= 1'b1;
        Inst_load      <= word;
        Inst_addr_load <= BASE_ADDR + offset;
        idx_q          <= idx_q + 16'd1;
      end
      if (csum_chk) begin
        if (byte_data == csum) begin
          load_done <= 1'b1;
          cpu_rst_n <= 1'b1;
        end else begin
          load_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_stream_loader.sv
// Scoreboard bench for inst_stream_loader.
// Two instances (base 0 and base 0x100) share one byte stream.
module tb_inst_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        br0, le0, cr0, dn0, er0;
  logic [31:0] addr0, inst0;
  logic        br1, le1, cr1, dn1, er1;
  logic [31:0] addr1, inst1;

  always #5 clk = ~clk;

  inst_stream_loader dut0 (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br0),
    .Inst_addr_load(addr0), .Inst_load(inst0),
    .load_en(le0), .cpu_rst_n(cr0),
    .load_done(dn0), .load_err(er0)
  );

  inst_stream_loader #(.BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br1),
    .Inst_addr_load(addr1), .Inst_load(inst1),
    .load_en(le1), .cpu_rst_n(cr1),
    .load_done(dn1), .load_err(er1)
  );

  typedef struct {
    logic [31:0] off;
    logic [31:0] word;
  } wr_t;

  wr_t         q0[$];
  wr_t         q1[$];
  logic [31:0] fw[$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for base-0 instance
  always @(negedge clk) begin
    if (le0) begin
      wr_t e;
      if (q0.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut0 write: got %h@%h expected none", inst0, addr0);
      end else begin
        e = q0.pop_front();
        chk("dut0 addr", addr0, 32'h0 + e.off);
        chk("dut0 data", inst0, e.word);
      end
    end
  end

  // Monitor for base-0x100 instance
  always @(negedge clk) begin
    if (le1) begin
      wr_t e;
      if (q1.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL dut1 write: got %h@%h expected none", inst1, addr1);
      end else begin
        e = q1.pop_front();
        chk("dut1 addr", addr1, 32'h100 + e.off);
        chk("dut1 data", inst1, e.word);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int tries;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (!(br0 && br1) && tries < 16) begin
      @(negedge clk);
      tries++;
    end
    if (tries == 16) begin
      n_checks++;
      n_err++;
      $display("FAIL byte_ready timeout: got 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic check_status(input string tag, input bit good);
    chk({tag, " done0"}, {31'd0, dn0}, {31'd0, good});
    chk({tag, " err0"},  {31'd0, er0}, {31'd0, !good});
    chk({tag, " cpu0"},  {31'd0, cr0}, {31'd0, good});
    chk({tag, " done1"}, {31'd0, dn1}, {31'd0, good});
    chk({tag, " err1"},  {31'd0, er1}, {31'd0, !good});
    chk({tag, " cpu1"},  {31'd0, cr1}, {31'd0, good});
  endtask

  // mode 0: correct checksum, 1: send forced value, 2: random wrong value
  task automatic send_frame(input string tag, input int mode,
                            input logic [7:0] forced, input int maxgap);
    logic [7:0]  cs;
    logic [7:0]  sent;
    logic [7:0]  b;
    logic [15:0] n;
    logic [31:0] w;
    wr_t         e;
    cs = 8'h00;
    n  = 16'(fw.size());
    send_byte(8'hA5, maxgap);
    send_byte(n[7:0], maxgap);
    send_byte(n[15:8], maxgap);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        if (k == 3) begin
          e.off  = 32'(i) * 32'd4;
          e.word = w;
          q0.push_back(e);
          q1.push_back(e);
        end
        send_byte(b, maxgap);
      end
    end
    if (mode == 0)      sent = cs;
    else if (mode == 1) sent = forced;
    else                sent = cs ^ 8'($urandom_range(255, 1));
    send_byte(sent, maxgap);
    chk({tag, " held"}, {31'd0, cr0}, 32'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    check_status(tag, sent == cs);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst load_en", {31'd0, le0}, 32'd0);
    chk("rst cpu_rst_n", {31'd0, cr0}, 32'd0);
    chk("rst done", {31'd0, dn0}, 32'd0);
    chk("rst err", {31'd0, er0}, 32'd0);
    chk("rst addr", addr0, 32'd0);
    chk("rst inst", inst1, 32'd0);
    chk("rst ready", {31'd0, br0}, 32'd1);
    rst_n = 1'b1;

    fw = '{32'h0000_0013, 32'h0010_0093};
    send_frame("t1", 0, 8'h00, 0);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    fw = {};
    send_frame("t2", 0, 8'h00, 0);

    fw = '{32'h1234_5678};
    send_frame("t3", 1, 8'h00, 0);

    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4 rst cpu", {31'd0, cr0}, 32'd0);
    chk("t4 rst err", {31'd0, er0}, 32'd0);
    chk("t4 rst en", {31'd0, le1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fw = '{32'hDEAD_BEEF};
    send_frame("t4", 0, 8'h00, 0);

    fw = '{$urandom, $urandom, $urandom};
    send_frame("t5", 0, 8'h00, 3);

    send_byte(8'hA5, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t6 cpu drop", {31'd0, cr0}, 32'd0);
    chk("t6 done clr", {31'd0, dn1}, 32'd0);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    @(negedge clk);
    byte_valid = 1'b0;
    check_status("t6", 1'b1);

    fw = '{32'hA5A5_A5A5, 32'h0000_00A5};
    send_frame("sync payload", 0, 8'h00, 0);

    for (int r = 0; r < 10; r++) begin
      fw = {};
      repeat ($urandom_range(4, 0)) fw.push_back($urandom);
      send_frame("rand", ($urandom_range(3, 0) == 0) ? 2 : 0,
                 8'h00, 2);
    end

    repeat (4) @(negedge clk);
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
